// File: rtl/uart_tx_if.sv
// Byte-stream handshake feeding the UART transmitter.
// The source (master) offers in_data with in_valid. The transmitter (slave) returns in_ready.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1-style UART transmitter with a one-entry holding register.
// A byte accepted while the line is busy waits in hold_q and is loaded the moment the
// shifter becomes free. Back-to-back frames therefore follow each other with no idle gap.
// All outputs come straight from flops.
module uart_tx #(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic      clk,
    input  logic      reset,
    uart_tx_if.slave  bus,
    output logic      tx,
    output logic      busy,
    output logic      done
);
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(DATA_BITS) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLK_DIV - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 tx_q, tx_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic accept_s;
    logic bit_end_s;
    logic load_s;

    assign accept_s  = bus.in_valid && in_ready_q;
    assign bit_end_s = (baud_q == BAUD_LAST);

    // Next-state logic for the shifter FSM, baud/bit/stop counters and holding register.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        stop_d      = stop_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        load_s      = 1'b0;

        // The baud counter is held at zero in IDLE, so the first bit after a load lasts exactly CLK_DIV cycles.
        if ((state_q == IDLE) || bit_end_s) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load_s  = 1'b1;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = STOP;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    if (stop_q == STOP_LAST) begin
                        // A waiting byte starts its frame straight out of the final stop bit.
                        if (hold_full_q) begin
                            load_s  = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_d  = stop_q + 1'b1;
                        state_d = STOP;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Load and accept are exclusive: in_ready is low whenever hold_full is set.
        if (load_s) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
        end else if (accept_s) begin
            hold_d      = bus.in_data;
            hold_full_d = 1'b1;
        end else begin
            hold_full_d = hold_full_q;
        end
    end

    // Registered outputs, derived from the next state so tx changes on the same edge as the FSM.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            IDLE:    tx_d = 1'b1;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        in_ready_d = ~hold_full_d;
        busy_d     = (state_d != IDLE) || hold_full_d;
        // Raised one cycle early so the registered pulse lands on the last cycle of the final stop bit.
        done_d     = (state_q == STOP) && (stop_q == STOP_LAST) && (baud_q == BAUD_PRE);
    end

    // State and output registers with synchronous reset; reset discards any frame or held byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_cnt_q   <= '0;
            stop_q      <= 1'b0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_q      <= stop_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign tx           = tx_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a stimulus process queues expected bytes, and a line monitor decodes frames on tx.
// The monitor checks each frame bit-by-bit against the queued byte.
module tb_uart_tx;
    logic clk = 1'b0;
    logic reset;
    logic tx1, busy1, done1;
    logic tx2, busy2, done2;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_if #(.DATA_BITS(8)) bus1();
    uart_tx_if #(.DATA_BITS(8)) bus2();

    uart_tx #(.CLK_DIV(16), .DATA_BITS(8), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .tx(tx1), .busy(busy1), .done(done1));
    uart_tx #(.CLK_DIV(16), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .tx(tx2), .busy(busy2), .done(done2));

    typedef struct {
        logic [7:0] data;
        bit         contig;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // monitor state
    bit         mon_active = 1'b0;
    int         mon_c = 0;
    int         mon_idle = 0;
    int         mon_start_cyc = 0;
    int         bit_err = 0;
    int         done_cnt = 0;
    int         stray_done = 0;
    exp_t       cur;
    logic [9:0] cur_bits;
    logic [7:0] rx_byte;
    int         accept_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line monitor: decodes each frame on tx1 and scores it against the front of exp_q.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_active = 1'b0;
                mon_idle   = 0;
            end else if (!mon_active) begin
                if (done1) stray_done++;
                if (tx1 === 1'b0) begin
                    mon_start_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_frame: got frame start at cycle %0d expected none", cyc);
                        cur.data   = 8'h00;
                        cur.contig = 1'b0;
                    end else begin
                        cur = exp_q.pop_front();
                        if (cur.contig) check("contiguous_gap", mon_idle, 0);
                    end
                    cur_bits   = {1'b1, cur.data, 1'b0};
                    mon_active = 1'b1;
                    mon_c      = 0;
                    bit_err    = 0;
                    done_cnt   = 0;
                    rx_byte    = 8'h00;
                end else begin
                    mon_idle++;
                end
            end else begin
                mon_c++;
                if (tx1 !== cur_bits[mon_c / 16]) bit_err++;
                if ((mon_c % 16 == 8) && (mon_c / 16 >= 1) && (mon_c / 16 <= 8))
                    rx_byte[mon_c / 16 - 1] = tx1;
                if (done1) begin
                    done_cnt++;
                    if (mon_c != 159) bit_err++;
                end
                if (mon_c == 159) begin
                    check("frame_bit_errors", bit_err, 0);
                    check("rx_byte", rx_byte, cur.data);
                    check("done_pulses", done_cnt, 1);
                    mon_active = 1'b0;
                    mon_idle   = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit contig);
        exp_t e;
        bit   ok;
        e.data   = b;
        e.contig = contig;
        exp_q.push_back(e);
        bus1.in_data  = b;
        bus1.in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (bus1.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                accept_cyc    = cyc;
                bus1.in_valid = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no acceptance of %0h expected acceptance", b);
            bus1.in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk);
            #1;
            if ((exp_q.size() == 0) && !mon_active && (busy1 === 1'b0)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL wait_idle_timeout: got %0d bytes pending busy=%b expected idle", exp_q.size(), busy1);
            exp_q.delete();
        end
    endtask

    // Stimulus: directed scenarios; expected bytes are queued by send().
    initial begin : stimulus
        logic [10:0] bits2;
        int          err2;
        int          done2_cnt;

        reset         = 1'b1;
        bus1.in_valid = 1'b1;   // must be ignored while reset is high
        bus1.in_data  = 8'hEE;
        bus2.in_valid = 1'b0;
        bus2.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset         = 1'b0;
        bus1.in_valid = 1'b0;
        check("reset_tx", tx1, 1);
        check("reset_in_ready", bus1.in_ready, 1);
        check("reset_busy", busy1, 0);
        check("reset_done", done1, 0);
        check("reset_tx2", tx2, 1);
        repeat (2) @(posedge clk);
        #1;
        check("valid_in_reset_ignored", busy1, 0);

        // 1: single byte, latency and frame shape
        send(8'hA5, 1'b0);
        check("accept_tx_still_high", tx1, 1);
        check("accept_in_ready_low", bus1.in_ready, 0);
        check("accept_busy", busy1, 1);
        @(posedge clk);
        #1;
        check("fall_one_after_accept", tx1, 0);
        check("in_ready_after_load", bus1.in_ready, 1);
        wait_idle();
        check("idle_tx_high", tx1, 1);

        // 2: back-to-back frames
        send(8'h55, 1'b0);
        send(8'h0F, 1'b1);
        wait_idle();

        // 3: third byte waits until the held byte loads
        send(8'h55, 1'b0);
        send(8'h0F, 1'b1);
        send(8'h33, 1'b1);
        check("held_accept_cycle", accept_cyc - mon_start_cyc, 1);
        wait_idle();

        // 4: reset mid-frame drops the frame and the held byte
        send(8'hFF, 1'b0);
        send(8'h3C, 1'b1);
        repeat (67) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midreset_tx", tx1, 1);
        check("midreset_in_ready", bus1.in_ready, 1);
        check("midreset_busy", busy1, 0);
        check("midreset_done", done1, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("held_byte_lost", busy1, 0);
        send(8'h96, 1'b0);
        wait_idle();

        // 5: assorted patterns, back-to-back
        send(8'h00, 1'b0);
        send(8'h80, 1'b1);
        send(8'h7E, 1'b1);
        send(8'hFF, 1'b1);
        wait_idle();

        // 6: two stop bits on the second instance
        bits2 = {2'b11, 8'h01, 1'b0};
        err2 = 0;
        done2_cnt = 0;
        @(negedge clk);
        bus2.in_data  = 8'h01;
        bus2.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        check("sb2_accept_tx_high", tx2, 1);
        @(posedge clk);
        #1;
        check("sb2_fall", tx2, 0);
        for (int c = 0; c < 176; c++) begin
            @(negedge clk);
            if (tx2 !== bits2[c / 16]) err2++;
            if (done2 === 1'b1) begin
                done2_cnt++;
                if (c != 175) err2++;
            end
        end
        check("sb2_frame_bit_errors", err2, 0);
        check("sb2_done_pulses", done2_cnt, 1);
        @(negedge clk);
        check("sb2_after_tx", tx2, 1);
        check("sb2_after_done", done2, 0);
        check("sb2_after_busy", busy2, 0);

        check("stray_done_pulses", stray_done, 0);
        check("pending_expected", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
